// File: rtl/sub_arb_pkg.sv
// Shared constants, id type and saturation limits for the shared-subtractor arbiter.
// The saturation limits are used only when SUB_ARB_SATURATE_EN is defined.
package sub_arb_pkg;

  localparam int unsigned DWIDTH_DEF = 32;
  localparam int unsigned NREQ_DEF   = 4;
  localparam int unsigned IDW_DEF    = $clog2(NREQ_DEF);

  typedef logic [IDW_DEF-1:0] req_id_t;

  // Largest positive value of a dw-bit two's-complement number (low dw bits used).
  function automatic logic [63:0] sat_max(input int unsigned dw);
    return (64'(1) << (dw - 1)) - 64'(1);
  endfunction

  // Most negative value of a dw-bit two's-complement number (low dw bits used).
  function automatic logic [63:0] sat_min(input int unsigned dw);
    return 64'(1) << (dw - 1);
  endfunction

endpackage

// File: rtl/sub_share_arbiter_rr_arbiter.sv
// Round-robin priority select: the first set req bit at or above ptr, wrapping,
// wins. Produces a one-hot grant, its encoded index and a found flag.
module rr_arbiter #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant_c,
  output logic [IDW-1:0]  idx_c,
  output logic            any_c
);

  logic [IDW-1:0] cand;
  logic           found;

  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IDW'((32'(ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        found          = 1'b1;
        grant_c[cand]  = 1'b1;
        idx_c          = cand;
      end
    end
    any_c = found;
  end

endmodule

// File: rtl/sub_share_arbiter.sv
// One signed subtractor shared round-robin among NREQ valid/ready requesters,
// one-cycle registered result port. Define SUB_ARB_SATURATE_EN to clamp on overflow.
module sub_share_arbiter
  import sub_arb_pkg::*;
#(
  parameter  int unsigned DWIDTH = DWIDTH_DEF,
  parameter  int unsigned NREQ   = NREQ_DEF,
  localparam int unsigned IDW    = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DWIDTH-1:0] req_a,
  input  logic [NREQ*DWIDTH-1:0] req_b,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [DWIDTH-1:0]      res_data,
  output logic [IDW-1:0]         res_id,
  output logic                   res_ovf,
  output logic                   busy
);

  logic [IDW-1:0]    ptr;
  logic              can_load_c;
  logic [NREQ-1:0]   req_masked_c;
  logic [NREQ-1:0]   grant_c;
  logic [IDW-1:0]    gnt_idx_c;
  logic              gnt_any_c;
  logic [IDW-1:0]    ptr_next_c;
  logic [DWIDTH-1:0] a_arr [NREQ];
  logic [DWIDTH-1:0] b_arr [NREQ];
  logic [DWIDTH-1:0] op_a_c;
  logic [DWIDTH-1:0] op_b_c;
  logic [DWIDTH-1:0] diff_c;
  logic [DWIDTH-1:0] res_next_c;
  logic              ovf_c;

  // A new result may be loaded when the register is empty or being drained.
  assign can_load_c   = !res_valid || res_ready;
  assign req_masked_c = (can_load_c && !rst) ? req_valid : '0;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr_arbiter (
    .req     (req_masked_c),
    .ptr     (ptr),
    .grant_c (grant_c),
    .idx_c   (gnt_idx_c),
    .any_c   (gnt_any_c)
  );

  assign req_ready = grant_c;
  assign busy      = res_valid || (|req_valid);

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[g*DWIDTH +: DWIDTH];
    assign b_arr[g] = req_b[g*DWIDTH +: DWIDTH];
  end

  assign ptr_next_c = (gnt_idx_c == IDW'(NREQ - 1)) ? '0 : gnt_idx_c + IDW'(1);

  // Shared subtractor with signed-overflow detection on the granted operands.
  always_comb begin
    op_a_c     = a_arr[gnt_idx_c];
    op_b_c     = b_arr[gnt_idx_c];
    diff_c     = op_a_c - op_b_c;
    ovf_c      = (op_a_c[DWIDTH-1] != op_b_c[DWIDTH-1]) &&
                 (diff_c[DWIDTH-1] != op_a_c[DWIDTH-1]);
    res_next_c = diff_c;
`ifdef SUB_ARB_SATURATE_EN
    // A negative minuend can only overflow downward, a positive one upward.
    if (ovf_c) begin
      res_next_c = op_a_c[DWIDTH-1] ? DWIDTH'(sat_min(DWIDTH)) : DWIDTH'(sat_max(DWIDTH));
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
      res_ovf   <= 1'b0;
      ptr       <= '0;
    end else if (gnt_any_c) begin
      res_valid <= 1'b1;
      res_data  <= res_next_c;
      res_id    <= gnt_idx_c;
      res_ovf   <= ovf_c;
      ptr       <= ptr_next_c;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sub_share_arbiter.sv
// Scoreboard bench for sub_share_arbiter: directed cases from the plan plus a random
// phase, checked against a plain-arithmetic model (honours SUB_ARB_SATURATE_EN).
module tb_sub_share_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           res_valid;
  logic           res_ready;
  logic [W-1:0]   res_data;
  logic [1:0]     res_id;
  logic           res_ovf;
  logic           busy;

  always #5 clk = ~clk;

  sub_share_arbiter #(.DWIDTH(W), .NREQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_ovf   (res_ovf),
    .busy      (busy)
  );

  typedef struct {
    logic [W-1:0] d;
    int           id;
    bit           ovf;
  } exp_t;

  exp_t         q[$];
  int           checks = 0;
  int           errors = 0;
  bit           pv[N];
  logic [W-1:0] pa[N];
  logic [W-1:0] pb[N];
  int           mptr;
  bit           mvalid;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Expected result from wide signed arithmetic: overflow is "outside the W-bit range".
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int id);
    exp_t   e;
    longint d;
    longint mx;
    longint mn;
    mx    = (longint'(1) <<< (W - 1)) - 1;
    mn    = -(longint'(1) <<< (W - 1));
    d     = longint'($signed(a)) - longint'($signed(b));
    e.ovf = (d > mx) || (d < mn);
    e.d   = W'(d);
`ifdef SUB_ARB_SATURATE_EN
    if (d > mx) e.d = W'(mx);
    else if (d < mn) e.d = W'(mn);
`endif
    e.id  = id;
    return e;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0001;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic drive(input bit rr);
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = pv[i];
      req_a[i*W +: W]    = pa[i];
      req_b[i*W +: W]    = pb[i];
    end
    res_ready = rr;
  endtask

  // One clock cycle: called just after a rising edge, returns the granted index or -1.
  task automatic step(input bit rr, output int g);
    logic [N-1:0] eg;
    bit           anyp;
    int           j;
    drive(rr);
    #1;
    g    = -1;
    anyp = 1'b0;
    for (int k = 0; k < N; k++) begin
      anyp = anyp | pv[k];
      j = (mptr + k) % N;
      if ((!mvalid || rr) && g < 0 && pv[j]) g = j;
    end
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(eg));
    chk("res_valid", 64'(res_valid), 64'(mvalid));
    chk("busy", 64'(busy), 64'(mvalid | anyp));
    if (g >= 0) begin
      q.push_back(model(pa[g], pb[g], g));
      pv[g]  = 1'b0;
      mptr   = (g + 1) % N;
      mvalid = 1'b1;
    end else if (rr) begin
      mvalid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '1;
    res_ready = 1'b1;
    #1;
    chk("rst res_valid", 64'(res_valid), 64'(0));
    chk("rst res_data", 64'(res_data), 64'(0));
    chk("rst res_id", 64'(res_id), 64'(0));
    chk("rst res_ovf", 64'(res_ovf), 64'(0));
    chk("rst req_ready", 64'(req_ready), 64'(0));
    q.delete();
    for (int i = 0; i < N; i++) pv[i] = 1'b0;
    mptr      = 0;
    mvalid    = 1'b0;
    req_valid = '0;
    rst       = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int  g;
    bit  anyp;
    for (int c = 0; c < 40; c++) begin
      anyp = 1'b0;
      for (int i = 0; i < N; i++) anyp = anyp | pv[i];
      if (!anyp && !mvalid) break;
      step(1'b1, g);
    end
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    pv[i] = 1'b1;
    pa[i] = a;
    pb[i] = b;
  endtask

  // Monitor: whenever a result is presented, it must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && res_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected result at %0t: got id %0d data %0h", $time, res_id, res_data);
      end else begin
        chk("res_data", 64'(res_data), 64'(q[0].d));
        chk("res_id", 64'(res_id), 64'(q[0].id));
        chk("res_ovf", 64'(res_ovf), 64'(q[0].ovf));
        if (res_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    int           g;
    logic [W-1:0] e1;
    logic [W-1:0] e2;
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      pv[i] = 1'b0;
      pa[i] = '0;
      pb[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Single request after reset.
    set_req(0, 32'd10, 32'd3);
    step(1'b1, g);
    chk("single grant", 64'(g), 64'(0));
    chk("single data", 64'(res_data), 64'(7));
    chk("single id", 64'(res_id), 64'(0));
    drain();

    // Fairness with all requesters continuously valid.
    do_reset();
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < N; i++) if (!pv[i]) set_req(i, rnd_op(), rnd_op());
      step(1'b1, g);
      chk("rr order", 64'(g), 64'(c % N));
    end
    drain();

    // Backpressure: held result blocks req1 until res_ready returns.
    do_reset();
    set_req(0, 32'd100, 32'd1);
    step(1'b1, g);
    set_req(1, 32'd5, 32'd9);
    for (int c = 0; c < 5; c++) begin
      step(1'b0, g);
      chk("bp no grant", 64'(g), 64'(-1));
    end
    step(1'b1, g);
    chk("bp release grant", 64'(g), 64'(1));
    drain();

    // Overflow corners.
`ifdef SUB_ARB_SATURATE_EN
    e1 = 32'h7FFF_FFFF;
    e2 = 32'h8000_0000;
`else
    e1 = 32'h8000_0000;
    e2 = 32'h7FFF_FFFF;
`endif
    set_req(0, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    step(1'b1, g);
    chk("pos ovf flag", 64'(res_ovf), 64'(1));
    chk("pos ovf data", 64'(res_data), 64'(e1));
    set_req(0, 32'h8000_0000, 32'h0000_0001);
    step(1'b1, g);
    chk("neg ovf flag", 64'(res_ovf), 64'(1));
    chk("neg ovf data", 64'(res_data), 64'(e2));
    drain();

    // Sparse requests move the pointer past each granted requester.
    do_reset();
    set_req(3, 32'd1, 32'd2);
    step(1'b1, g);
    chk("sparse req3", 64'(g), 64'(3));
    step(1'b1, g);
    set_req(1, 32'd20, 32'd30);
    step(1'b1, g);
    chk("sparse req1", 64'(g), 64'(1));
    set_req(0, 32'd4, 32'd4);
    set_req(2, 32'd8, 32'd2);
    step(1'b1, g);
    chk("sparse ptr=2", 64'(g), 64'(2));
    drain();

    // Asynchronous reset between edges while a result is held.
    for (int i = 0; i < N; i++) set_req(i, rnd_op(), rnd_op());
    step(1'b1, g);
    step(1'b0, g);
    #2;
    do_reset();
    set_req(2, 32'd7, 32'd1);
    set_req(0, 32'd6, 32'd2);
    step(1'b1, g);
    chk("post rst grant", 64'(g), 64'(0));
    drain();

    // Random traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!pv[i] && $urandom_range(0, 1) == 1) set_req(i, rnd_op(), rnd_op());
      step($urandom_range(0, 3) != 0, g);
    end
    drain();
    chk("scoreboard empty", 64'(q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
